// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and serialises it
// as start, LSB-first data, optional parity and stop bits, one bit per baud tick.
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter logic        PARITY_EN  = 1'b0,
    parameter logic        PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_baud_tick,
    input  logic                 i_valid,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int unsigned      IDX_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] data_q,  data_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic                 stop_q,  stop_d;
    logic                 tx_d;
    logic                 ready_d;
    logic                 done_d;
    logic                 parity_c;

    assign parity_c = (^data_q) ^ PARITY_ODD;

    // State and registered outputs; reset parks the line high and ready.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            o_tx    <= 1'b1;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            o_tx    <= tx_d;
            o_ready <= ready_d;
            o_busy  <= ~ready_d;
            o_done  <= done_d;
        end
    end

    // Next-state logic: every move after the handshake is paced by a baud tick,
    // so the tick seen in the handshake cycle itself never advances the frame.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        tx_d    = o_tx;
        ready_d = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                if (i_valid) begin
                    data_d  = i_data;
                    state_d = ALIGN;
                    ready_d = 1'b0;
                end
            end
            ALIGN: begin
                tx_d = 1'b1;
                if (i_baud_tick) begin
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (i_baud_tick) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (i_baud_tick) begin
                    if (idx_q == LAST_IDX) begin
                        if (PARITY_EN) begin
                            state_d = PARITY;
                            tx_d    = parity_c;
                        end else begin
                            state_d = STOP;
                            stop_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = data_q[idx_q + IDX_W'(1)];
                    end
                end
            end
            PARITY: begin
                if (i_baud_tick) begin
                    state_d = STOP;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (i_baud_tick) begin
                    if (stop_q == LAST_STOP) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (8N1, 8E1, 8O1, 8N2) share clock,
// reset, baud tick and data; each has its own valid. Tick every 4 clocks.
`timescale 1ns/1ps
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] valid;
    logic [7:0] data;
    logic [3:0] ready;
    logic [3:0] tx;
    logic [3:0] busy;
    logic [3:0] done;

    int  n_cmp;
    int  n_fail;
    int  done_cnt [4];
    int  tcnt;
    time t_last;

    uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_8n1 (
        .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_valid(valid[0]), .i_data(data),
        .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0]), .o_done(done[0]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_8e1 (
        .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_valid(valid[1]), .i_data(data),
        .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1]), .o_done(done[1]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_8o1 (
        .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_valid(valid[2]), .i_data(data),
        .o_ready(ready[2]), .o_tx(tx[2]), .o_busy(busy[2]), .o_done(done[2]));
    uart_tx #(.DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_8n2 (
        .i_clk(clk), .i_rst(rst), .i_baud_tick(tick), .i_valid(valid[3]), .i_data(data),
        .o_ready(ready[3]), .o_tx(tx[3]), .o_busy(busy[3]), .o_done(done[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Upstream baud counter: one-cycle tick every 4 clocks.
    initial begin
        tick = 1'b0;
        tcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            tcnt = (tcnt + 1) % 4;
            tick = (tcnt == 0);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for the next tick (line must hold meanwhile), returns o_tx after it.
    task automatic next_bit(input int sel, input logic prev, output logic b);
        int k = 0;
        while (tick !== 1'b1 && k < 20) begin
            chk("hold", 32'(tx[sel]), 32'(prev));
            @(negedge clk);
            k++;
        end
        if (k >= 20) begin
            n_cmp++;
            n_fail++;
            $error("FAIL tick_timeout: observed %0d cycles expected <20", k);
        end
        @(negedge clk);
        b = tx[sel];
    endtask

    task automatic offer(input int sel, input logic [7:0] d);
        @(negedge clk);
        chk("ready_idle", 32'(ready[sel]), 32'd1);
        data       = d;
        valid[sel] = 1'b1;
        @(negedge clk);
        chk("ready_hs", 32'(ready[sel]), 32'd0);
        chk("busy_hs", 32'(busy[sel]), 32'd1);
    endtask

    // Checks n bits (bit i of exp sent i-th) at 4-clock spacing, then the done pulse.
    task automatic frame_check(input int sel, input logic [15:0] exp, input int n, input int first_gap);
        logic prev;
        logic b;
        prev = 1'b1;
        for (int i = 0; i < n; i++) begin
            next_bit(sel, prev, b);
            chk($sformatf("u%0d_bit%0d", sel, i), 32'(b), 32'(exp[i]));
            if (i > 0) chk("spacing", 32'($time - t_last), 32'd40);
            else if (first_gap > 0) chk("gap", 32'($time - t_last), 32'(first_gap));
            t_last = $time;
            prev   = b;
        end
        next_bit(sel, prev, b);
        chk("done", 32'(done[sel]), 32'd1);
        chk("ready_end", 32'(ready[sel]), 32'd1);
        chk("tx_end", 32'(b), 32'd1);
        @(negedge clk);
        chk("done_width", 32'(done[sel]), 32'd0);
    endtask

    initial begin
        int   snap;
        int   k;
        logic b;
        n_cmp  = 0;
        n_fail = 0;
        t_last = 0;
        for (int i = 0; i < 4; i++) done_cnt[i] = 0;
        rst   = 1'b1;
        valid = 4'b0;
        data  = 8'h00;

        // Reset state on all instances
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'hF);
        chk("rst_ready", 32'(ready), 32'hF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 8N1 0xA5, data changed mid-frame
        offer(0, 8'hA5);
        valid[0] = 1'b0;
        data     = 8'hFF;
        frame_check(0, 16'({1'b1, 8'hA5, 1'b0}), 10, 0);

        // 8E1 and 8O1 with 0xA5: parity 0 then 1
        offer(1, 8'hA5);
        valid[1] = 1'b0;
        frame_check(1, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 0);
        offer(2, 8'hA5);
        valid[2] = 1'b0;
        frame_check(2, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, 0);

        // 8N2 with 0x00: nine low intervals, two high
        offer(3, 8'h00);
        valid[3] = 1'b0;
        frame_check(3, 16'({2'b11, 8'h00, 1'b0}), 11, 0);

        // Back-to-back with valid held: 0x55 then 0xAA
        snap = done_cnt[0];
        offer(0, 8'h55);
        data = 8'hAA;
        frame_check(0, 16'({1'b1, 8'h55, 1'b0}), 10, 0);
        chk("b2b_ready_hs", 32'(ready[0]), 32'd0);
        valid[0] = 1'b0;
        data     = 8'h0F;
        frame_check(0, 16'({1'b1, 8'hAA, 1'b0}), 10, 80);
        chk("b2b_done_count", 32'(done_cnt[0] - snap), 32'd2);

        // Handshake coincident with a tick, data changed right after
        k = 0;
        @(negedge clk);
        while (tick !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("align_tick_found", 32'(tick), 32'd1);
        data     = 8'hA5;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        data     = 8'h5A;
        chk("coinc_ready", 32'(ready[0]), 32'd0);
        frame_check(0, 16'({1'b1, 8'hA5, 1'b0}), 10, 0);

        // Reset during data bit 3, then a fresh 0x3C frame
        offer(0, 8'h00);
        valid[0] = 1'b0;
        b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            next_bit(0, b, b);
            chk($sformatf("pre_rst_bit%0d", i), 32'(b), 32'd0);
        end
        snap = done_cnt[0];
        rst  = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx[0]), 32'd1);
        chk("mid_rst_ready", 32'(ready[0]), 32'd1);
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        chk("mid_rst_done", 32'(done[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        data     = 8'h3C;
        valid[0] = 1'b1;
        @(negedge clk);
        valid[0] = 1'b0;
        chk("post_rst_hs", 32'(ready[0]), 32'd0);
        chk("rst_no_done", 32'(done_cnt[0] - snap), 32'd0);
        frame_check(0, 16'({1'b1, 8'h3C, 1'b0}), 10, 0);

        // Total done pulses per instance
        repeat (2) @(negedge clk);
        chk("done_total_8n1", 32'(done_cnt[0]), 32'd5);
        chk("done_total_8e1", 32'(done_cnt[1]), 32'd1);
        chk("done_total_8o1", 32'(done_cnt[2]), 32'd1);
        chk("done_total_8n2", 32'(done_cnt[3]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
